ipsxb_rst_seq_ctrl: RTL and testbench
=====================================

// Module: ipsxb_rst_seq_ctrl
// PURPOSE
//  Power-up/recovery reset sequencer for the DDR subsystem (PLL -> DLL/PHY -> controller -> user).
//  Holds all stage resets asserted, then releases them one at a time, waiting for each stage's async ack.
//  Acks are lock/ready flags from other domains; each stage settles for a fixed time after its ack.
//  Sits between top-level reset and the per-domain reset synchronizers; retries on timeout or lost lock.
// PARAMETERS
//  NUM_STAGES   4      number of reset stages, released in index order 0..NUM_STAGES-1
//  CNT_W        16     width of shared hold/settle/timeout counter
//  HOLD_CYC     64     cycles all resets held asserted in ASSERT state (>=1)
//  SETTLE_CYC   256    cycles waited after a stage ack before releasing next stage (>=1)
//  TIMEOUT_CYC  50000  max cycles in WAIT_ACK per stage before failure (< 2**CNT_W)
//  MAX_RETRY    3      failed attempts tolerated before ERROR (retry_cnt width = 2 bits min, sized $clog2(MAX_RETRY+1))
// PORTS
//  clk          in   1              system clock
//  rst          in   1              asynchronous, active-high reset
//  start        in   1              1-cycle pulse: begin sequence from IDLE/DONE/ERROR
//  soft_rst     in   1              1-cycle pulse: abort, clear retry_cnt, restart at ASSERT from any state
//  stage_ack    in   NUM_STAGES     async per-stage lock/ready; synchronized internally (2 flops)
//  stage_rst_n  out  NUM_STAGES     active-low stage resets, registered
//  seq_done     out  1              all stages released and acked, registered
//  seq_err      out  1              sticky failure after MAX_RETRY retries, registered
//  cur_stage    out  $clog2(NUM_STAGES) stage index under service
//  retry_cnt    out  $clog2(MAX_RETRY+1) attempts failed in current run
// BEHAVIOUR
//  Reset values: stage_rst_n=0, seq_done=0, seq_err=0, cur_stage=0, retry_cnt=0, state=IDLE, cnt=0.
//  ack_s = stage_ack after 2-flop sync; ack latency 2 clk from input edge to FSM.
//  IDLE: all stage_rst_n=0. start -> ASSERT, cnt=0.
//  ASSERT: all stage_rst_n=0; cnt++; at cnt==HOLD_CYC-1 -> RELEASE, cur_stage=0.
//  RELEASE (1 cycle): stage_rst_n[cur_stage]<=1 (lower stages stay 1) -> WAIT_ACK, cnt=0.
//  WAIT_ACK: ack_s[cur_stage]=1 -> SETTLE, cnt=0; else cnt++; at cnt==TIMEOUT_CYC-1 -> FAIL.
//  SETTLE: cnt++; at cnt==SETTLE_CYC-1: last stage -> DONE; else cur_stage++, -> RELEASE.
//  SETTLE/WAIT_ACK: any lower stage ack_s[j<cur_stage] dropping -> FAIL (lost lock).
//  DONE: seq_done=1; any ack_s[j]=0 -> FAIL, seq_done<=0 same edge; start ignored.
//  FAIL (1 cycle): all stage_rst_n<=0, seq_done<=0; retry_cnt==MAX_RETRY -> ERROR; else retry_cnt++, -> ASSERT, cnt=0.
//  ERROR: seq_err=1, resets held asserted; leave only via start or soft_rst (both clear seq_err, retry_cnt, -> ASSERT).
//  start in ASSERT/RELEASE/WAIT_ACK/SETTLE: ignored. start in DONE: ignored.
//  soft_rst has priority over start and over every ack/timeout event in the same cycle.
//  soft_rst: all stage_rst_n<=0, seq_done<=0, seq_err<=0, retry_cnt<=0, cur_stage<=0 -> ASSERT.
//  rst mid-operation: all outputs return to reset values asynchronously; sync flops cleared to 0.
//  retry_cnt saturates at MAX_RETRY; cnt never wraps (bounded by compare).
//  Resets released monotonically within one attempt: stage k never released before stage k-1 acked+settled.
// STRUCTURE
//  Shared package ipsxb_rst_seq_pkg: state encoding localparams (IDLE, ASSERT, RELEASE, WAIT_ACK,
//    SETTLE, DONE, FAIL, ERROR) and stage-index constants for DDR (STG_PLL=0, STG_PHY=1, STG_CTRL=2, STG_USER=3).
//  Sub-module ipsxb_ack_sync: NUM_STAGES-wide 2-flop synchronizer, async active-high clear to 0.
//  Single FSM + one shared CNT_W counter; no other submodules.
// TESTING
//  Params HOLD=4, SETTLE=8, TIMEOUT=32, MAX_RETRY=2, N=4 unless noted.
//  1 Nominal: start, raise ack[k] 5 clk after stage_rst_n[k] rises -> releases in order, seq_done=1, retry_cnt=0.
//  2 Timeout: ack[2] never rises -> FAIL after 32 WAIT_ACK cycles, all resets low, retry_cnt 1,2, then seq_err=1.
//  3 Lost lock: in DONE drop ack[0] -> seq_done=0 within 3 clk, all stage_rst_n=0, retry_cnt=1, resequence completes.
//  4 soft_rst same cycle as ack[1] rise in WAIT_ACK -> ASSERT wins, stage_rst_n=0, retry_cnt=0, cur_stage=0.
//  5 Async rst asserted in SETTLE of stage 2 -> all outputs 0 immediately; start after release -> full sequence.
//  6 start while busy and in DONE -> no state change; start in ERROR -> seq_err=0, fresh sequence.

Source files
------------

// File: rtl/ipsxb_rst_seq_pkg.sv
// Shared definitions for the DDR reset sequencer: FSM state encoding and
// the stage index assignment of the DDR reset chain.
package ipsxb_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6,
    ST_ERROR    = 3'd7
  } seq_state_e;

  localparam int unsigned STG_PLL        = 32'd0;
  localparam int unsigned STG_PHY        = 32'd1;
  localparam int unsigned STG_CTRL       = 32'd2;
  localparam int unsigned STG_USER       = 32'd3;
  localparam int unsigned DDR_NUM_STAGES = 32'd4;

endpackage

// File: rtl/ipsxb_ack_sync.sv
// Two-flop synchronizer for the per-stage lock/ready acks coming from other
// clock domains; cleared to 0 by the asynchronous reset.
module ipsxb_ack_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Metastability filter: two back-to-back capture flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ipsxb_rst_seq_ctrl.sv
// DDR reset sequencer: holds every stage in reset, then releases stages in
// index order, waiting for each ack plus a settle time; retries on failure.
module ipsxb_rst_seq_ctrl
  import ipsxb_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYC    = 64,
  parameter int SETTLE_CYC  = 256,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  soft_rst,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  seq_err,
  output logic [SW-1:0]         cur_stage,
  output logic [RW-1:0]         retry_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]    LAST_STG    = SW'(NUM_STAGES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

  seq_state_e            state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [SW-1:0]         stage_r, stage_s;
  logic [RW-1:0]         retry_r, retry_s;
  logic [NUM_STAGES-1:0] rst_n_r, rst_n_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic [NUM_STAGES-1:0] ack_sync_s;
  logic [NUM_STAGES-1:0] lower_mask_s;
  logic                  lost_lock_s;
  logic                  cur_ack_s;
  logic                  all_ack_s;

  ipsxb_ack_sync #(.W(NUM_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (stage_ack),
    .q   (ack_sync_s)
  );

  // Stages below the one under service must keep their lock
  assign lower_mask_s = (NUM_STAGES'(1) << stage_r) - NUM_STAGES'(1);
  assign lost_lock_s  = |(lower_mask_s & ~ack_sync_s);
  assign cur_ack_s    = ack_sync_s[stage_r];
  assign all_ack_s    = &ack_sync_s;

  // Next-state and next-output decode; soft_rst overrides every event
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    retry_s = retry_r;
    rst_n_s = rst_n_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    if (soft_rst) begin
      state_s = ST_ASSERT;
      cnt_s   = {CNT_W{1'b0}};
      stage_s = {SW{1'b0}};
      retry_s = {RW{1'b0}};
      rst_n_s = {NUM_STAGES{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          rst_n_s = {NUM_STAGES{1'b0}};
          if (start) begin
            state_s = ST_ASSERT;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ASSERT: begin
          rst_n_s = {NUM_STAGES{1'b0}};
          if (cnt_r == HOLD_LAST) begin
            state_s = ST_RELEASE;
            stage_s = {SW{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          rst_n_s[stage_r] = 1'b1;
          state_s          = ST_WAIT_ACK;
          cnt_s            = {CNT_W{1'b0}};
        end
        ST_WAIT_ACK: begin
          if (lost_lock_s) begin
            state_s = ST_FAIL;
          end else if (cur_ack_s) begin
            state_s = ST_SETTLE;
            cnt_s   = {CNT_W{1'b0}};
          end else if (cnt_r == TO_LAST) begin
            state_s = ST_FAIL;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (lost_lock_s) begin
            state_s = ST_FAIL;
          end else if (cnt_r == SETTLE_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (stage_r == LAST_STG) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              stage_s = stage_r + SW'(1);
              state_s = ST_RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!all_ack_s) begin
            state_s = ST_FAIL;
          end else begin
            done_s = 1'b1;
          end
        end
        ST_FAIL: begin
          rst_n_s = {NUM_STAGES{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          if (retry_r == RETRY_MAX) begin
            state_s = ST_ERROR;
            err_s   = 1'b1;
          end else begin
            retry_s = retry_r + RW'(1);
            state_s = ST_ASSERT;
          end
        end
        ST_ERROR: begin
          rst_n_s = {NUM_STAGES{1'b0}};
          if (start) begin
            state_s = ST_ASSERT;
            cnt_s   = {CNT_W{1'b0}};
            stage_s = {SW{1'b0}};
            retry_s = {RW{1'b0}};
          end else begin
            err_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          rst_n_s = {NUM_STAGES{1'b0}};
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      stage_r <= {SW{1'b0}};
      retry_r <= {RW{1'b0}};
      rst_n_r <= {NUM_STAGES{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
      retry_r <= retry_s;
      rst_n_r <= rst_n_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign stage_rst_n = rst_n_r;
  assign seq_done    = done_r;
  assign seq_err     = err_r;
  assign cur_stage   = stage_r;
  assign retry_cnt   = retry_r;

endmodule

// File: tb/tb_ipsxb_rst_seq_ctrl.sv
// Bench for the DDR reset sequencer: a stage environment answers each released
// reset with an ack after a random delay; expected event cycles come from a timing model.
module tb_ipsxb_rst_seq_ctrl;

  localparam int N       = 4;
  localparam int HOLD    = 4;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int MAXR    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         soft_rst;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst_n;
  logic         seq_done;
  logic         seq_err;
  logic [1:0]   cur_stage;
  logic [1:0]   retry_cnt;

  int           cyc;
  int           n_checks;
  int           n_errors;
  int           rise_cyc [N];
  int           dly [N];
  bit           broken [N];
  logic [N-1:0] prev_rst_n;
  int           busy_start_cyc;
  int           soft_cyc;

  ipsxb_rst_seq_ctrl #(
    .NUM_STAGES (N),
    .CNT_W      (16),
    .HOLD_CYC   (HOLD),
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TIMEOUT),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .soft_rst   (soft_rst),
    .stage_ack  (stage_ack),
    .stage_rst_n(stage_rst_n),
    .seq_done   (seq_done),
    .seq_err    (seq_err),
    .cur_stage  (cur_stage),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] mask(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < k; i++) m[i] = 1'b1;
    return m;
  endfunction

  // One clock: sample after the edge, then the stage environment answers.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++)
      if (stage_rst_n[k] && !prev_rst_n[k]) rise_cyc[k] = cyc;
    prev_rst_n = stage_rst_n;
    for (int k = 0; k < N; k++)
      stage_ack[k] = stage_rst_n[k] && !broken[k] && (cyc - rise_cyc[k] >= dly[k]);
    start    = (cyc + 1 == busy_start_cyc);
    soft_rst = (cyc + 1 == soft_cyc);
  endtask

  task automatic run_until(input int target);
    if (target < cyc || target > cyc + 5000) begin
      check_val("run_until_bound", cyc, target);
    end else begin
      while (cyc < target) step();
    end
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    step();
    s = cyc;
  endtask

  task automatic soft_restart(output int s);
    soft_cyc = cyc + 2;
    run_until(soft_cyc);
    s = cyc;
    check_val("soft_rst_n", 32'(stage_rst_n), 32'd0);
    check_val("soft_done", 32'(seq_done), 32'd0);
    check_val("soft_retry", 32'(retry_cnt), 32'd0);
  endtask

  task automatic randomize_dly();
    for (int k = 0; k < N; k++) dly[k] = int'($urandom_range(0, 8));
  endtask

  // Timing model: ASSERT entered at cycle s. Stage k released at r, ack seen by
  // the FSM 3 cycles after the raw ack, settle, then one RELEASE cycle.
  task automatic expect_seq(input int s, input int fail_stg, output int e);
    int r;
    int a;
    r = s + HOLD + 1;
    e = s;
    for (int k = 0; k < N; k++) begin
      run_until(r - 1);
      check_val($sformatf("pre_release%0d", k), 32'(stage_rst_n), 32'(mask(k)));
      run_until(r);
      check_val($sformatf("release%0d", k), 32'(stage_rst_n), 32'(mask(k + 1)));
      check_val($sformatf("cur_stage%0d", k), 32'(cur_stage), k);
      if (k == fail_stg) begin
        run_until(r + TIMEOUT + 1);
        check_val("timeout_rst_n", 32'(stage_rst_n), 32'd0);
        e = cyc;
        return;
      end
      a = r + dly[k] + 3;
      if (k == N - 1) begin
        run_until(a + SETTLE - 1);
        check_val("done_early", 32'(seq_done), 32'd0);
        run_until(a + SETTLE);
        check_val("done_set", 32'(seq_done), 32'd1);
        check_val("done_rst_n", 32'(stage_rst_n), 32'hF);
        e = cyc;
      end else begin
        r = a + SETTLE + 1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, e, m, j, f, r1, a1, r2, a2;
    cyc = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0; soft_rst = 1'b0; stage_ack = '0;
    prev_rst_n = '0; busy_start_cyc = -1; soft_cyc = -1;
    for (int k = 0; k < N; k++) begin
      rise_cyc[k] = 0; dly[k] = 0; broken[k] = 1'b0;
    end

    #2;
    check_val("rst_rst_n", 32'(stage_rst_n), 32'd0);
    check_val("rst_done", 32'(seq_done), 32'd0);
    check_val("rst_err", 32'(seq_err), 32'd0);
    check_val("rst_cur", 32'(cur_stage), 32'd0);
    check_val("rst_retry", 32'(retry_cnt), 32'd0);
    step(); step();
    rst = 1'b0;
    run_until(cyc + 3);
    check_val("idle_rst_n", 32'(stage_rst_n), 32'd0);

    // Nominal sequence, acks 5 cycles after release, start pulsed while busy
    for (int k = 0; k < N; k++) dly[k] = 5;
    pulse_start(s);
    busy_start_cyc = s + int'($urandom_range(2, 40));
    expect_seq(s, -1, e);
    check_val("nom_retry", 32'(retry_cnt), 32'd0);
    check_val("nom_err", 32'(seq_err), 32'd0);

    // start in DONE is ignored
    pulse_start(s);
    run_until(cyc + 20);
    check_val("done_start_done", 32'(seq_done), 32'd1);
    check_val("done_start_rst_n", 32'(stage_rst_n), 32'hF);
    check_val("done_start_cur", 32'(cur_stage), 32'd3);

    // Lost lock in DONE, then a full resequence
    j = int'($urandom_range(0, N - 1));
    run_until(cyc + int'($urandom_range(1, 10)));
    m = cyc;
    broken[j] = 1'b1;
    stage_ack[j] = 1'b0;
    run_until(m + 2);
    check_val("lost_done_hold", 32'(seq_done), 32'd1);
    run_until(m + 3);
    check_val("lost_done_drop", 32'(seq_done), 32'd0);
    run_until(m + 4);
    check_val("lost_rst_n", 32'(stage_rst_n), 32'd0);
    check_val("lost_retry", 32'(retry_cnt), 32'd1);
    broken[j] = 1'b0;
    randomize_dly();
    expect_seq(m + 4, -1, e);
    check_val("lost_retry_kept", 32'(retry_cnt), 32'd1);

    // soft_rst from DONE, a timed-out attempt, then soft_rst colliding with ack[1]
    soft_restart(s);
    randomize_dly();
    broken[N - 1] = 1'b1;
    expect_seq(s, N - 1, e);
    check_val("soft_pre_retry", 32'(retry_cnt), 32'd1);
    r1 = e + HOLD + 1 + dly[0] + 3 + SETTLE + 1;
    a1 = r1 + dly[1] + 3;
    soft_cyc = a1;
    run_until(a1 - 1);
    check_val("collide_pre_rst_n", 32'(stage_rst_n), 32'h3);
    check_val("collide_pre_cur", 32'(cur_stage), 32'd1);
    run_until(a1);
    check_val("collide_rst_n", 32'(stage_rst_n), 32'd0);
    check_val("collide_cur", 32'(cur_stage), 32'd0);
    check_val("collide_retry", 32'(retry_cnt), 32'd0);
    broken[N - 1] = 1'b0;
    expect_seq(a1, -1, e);

    // Persistent timeout on a random stage: retries exhaust into ERROR
    f = int'($urandom_range(0, N - 1));
    soft_restart(s);
    randomize_dly();
    broken[f] = 1'b1;
    for (int att = 1; att <= MAXR + 1; att++) begin
      expect_seq(s, f, e);
      s = e;
      if (att <= MAXR) begin
        check_val($sformatf("to_retry%0d", att), 32'(retry_cnt), att);
        check_val($sformatf("to_err%0d", att), 32'(seq_err), 32'd0);
      end
    end
    check_val("err_set", 32'(seq_err), 32'd1);
    check_val("err_retry", 32'(retry_cnt), MAXR);
    run_until(cyc + 10);
    check_val("err_sticky", 32'(seq_err), 32'd1);
    check_val("err_rst_n", 32'(stage_rst_n), 32'd0);

    // start in ERROR: fresh sequence
    broken[f] = 1'b0;
    pulse_start(s);
    check_val("err_start_err", 32'(seq_err), 32'd0);
    check_val("err_start_retry", 32'(retry_cnt), 32'd0);
    randomize_dly();
    expect_seq(s, -1, e);

    // Async rst during SETTLE of stage 2, then a full sequence
    soft_restart(s);
    randomize_dly();
    r2 = s + HOLD + 1 + (dly[0] + SETTLE + 4) + (dly[1] + SETTLE + 4);
    a2 = r2 + dly[2] + 3;
    run_until(a2 + int'($urandom_range(1, 6)));
    check_val("arst_pre_rst_n", 32'(stage_rst_n), 32'h7);
    check_val("arst_pre_cur", 32'(cur_stage), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_val("arst_rst_n", 32'(stage_rst_n), 32'd0);
    check_val("arst_cur", 32'(cur_stage), 32'd0);
    check_val("arst_done", 32'(seq_done), 32'd0);
    check_val("arst_err", 32'(seq_err), 32'd0);
    step(); step();
    rst = 1'b0;
    run_until(cyc + 3);
    check_val("arst_idle", 32'(stage_rst_n), 32'd0);
    pulse_start(s);
    expect_seq(s, -1, e);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
